// File: rtl/mult_nibble_seq_ctrl.sv
// Sequential W x W unsigned multiplier built from N*N passes of one shared 4x4 multiplier.
// Operands and the product each move over a valid/ready handshake, and every output is registered.
module mult_nibble_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic [3:0]     mul_a,
  output logic [3:0]     mul_b,
  input  logic [7:0]     mul_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int         N    = W / 4;
  localparam int         PW   = 2 * W;
  localparam logic [1:0] LAST = 2'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [PW-1:0] acc;
  logic [1:0]    i;
  logic [1:0]    j;
  logic [PW-1:0] acc_sum;

  // The partial product of nibble pair (i, j) carries weight 16^(i+j).
  assign acc_sum = acc + (PW'(mul_p) << (4 * (i + j)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: all state and outputs update with non-blocking assignments, so every
      // branch reads the pre-edge values of i, j and acc regardless of statement order.
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= in_a;
            b_r      <= in_b;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            mul_a    <= in_a[3:0];
            mul_b    <= in_b[3:0];
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          acc <= acc_sum;
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              product   <= acc_sum;
              out_valid <= 1'b1;
              mul_a     <= '0;
              mul_b     <= '0;
              state     <= DONE;
            end else begin
              i     <= i + 2'd1;
              mul_a <= a_r[4 * (i + 2'd1) +: 4];
              mul_b <= b_r[3:0];
            end
          end else begin
            j     <= j + 2'd1;
            mul_b <= b_r[4 * (j + 2'd1) +: 4];
          end
        end

        DONE: begin
          // in_ready rises only once back in IDLE, so a new operand waits one cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_nibble_seq_ctrl.sv
// Scoreboard bench for mult_nibble_seq_ctrl at W=8 and W=16, with each instance driving
// its own behavioural 4x4 multiplier. A cycle-level reference model derived from a*b is used.
module tb_mult_nibble_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8, mp8;
  logic [3:0]  ma8, mb8;
  logic [15:0] p8;

  logic        iv16, ir16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [7:0]  mp16;
  logic [3:0]  ma16, mb16;
  logic [31:0] p16;

  assign mp8  = 8'(ma8) * 8'(mb8);
  assign mp16 = 8'(ma16) * 8'(mb16);

  mult_nibble_seq_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .mul_a(ma8), .mul_b(mb8), .mul_p(mp8), .out_valid(ov8), .out_ready(or8),
    .product(p8), .busy(busy8)
  );

  mult_nibble_seq_ctrl #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .mul_a(ma16), .mul_b(mb16), .mul_p(mp16), .out_valid(ov16), .out_ready(or16),
    .product(p16), .busy(busy16)
  );

  typedef struct {
    int          unit;
    logic [31:0] prod;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          exp_busy[2];
  int          since[2];
  logic [15:0] cur_a[2];
  logic [15:0] cur_b[2];
  logic [31:0] last_p[2];
  int          n_done[2];
  int          n_issued[2];

  task automatic check(input string name, input int u, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [W=%0d] at %0t: got 0x%0h, expected 0x%0h",
               name, (u == 0) ? 8 : 16, $time, act, exp);
    end
  endtask

  // Model per unit: idle until accept, then N*N run cycles, then holds the product until it is taken.
  task automatic step(input int u, input logic iv, input logic ir, input logic bsy,
                      input logic ov, input logic ord, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] ma, input logic [3:0] mb,
                      input logic [31:0] p);
    int       n, k;
    bit       e_ov, e_run;
    logic [3:0] ea, eb;
    exp_t     e;
    n = (u == 0) ? 2 : 4;
    if (exp_busy[u]) since[u]++;
    e_ov  = exp_busy[u] && (since[u] >= n * n + 1);
    e_run = exp_busy[u] && !e_ov;
    check("busy", u, bsy, exp_busy[u]);
    check("in_ready", u, ir, !exp_busy[u]);
    check("out_valid", u, ov, e_ov);
    ea = 4'h0;
    eb = 4'h0;
    if (e_run) begin
      k  = since[u] - 1;
      ea = cur_a[u][4 * (k / n) +: 4];
      eb = cur_b[u][4 * (k % n) +: 4];
    end
    check("mul_pair", u, {ma, mb}, {ea, eb});
    if (e_ov) begin
      check("scoreboard_depth", u, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        check("scoreboard_unit", u, sb_q[0].unit, u);
        check("product", u, p, sb_q[0].prod);
      end
    end else if (!exp_busy[u]) begin
      check("product_hold", u, p, last_p[u]);
    end
    if (ov && ord) n_done[u]++;
    if (e_ov && ord) begin
      if (sb_q.size() > 0) begin
        e         = sb_q.pop_front();
        last_p[u] = e.prod;
      end
      exp_busy[u] = 1'b0;
    end else if (!exp_busy[u] && iv) begin
      exp_busy[u] = 1'b1;
      since[u]    = 0;
      cur_a[u]    = a;
      cur_b[u]    = b;
      e.unit      = u;
      e.prod      = 32'(a) * 32'(b);
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        exp_busy[u] = 1'b0;
        since[u]    = 0;
        last_p[u]   = '0;
      end
      sb_q.delete();
    end else begin
      step(0, iv8, ir8, busy8, ov8, or8, 16'(a8), 16'(b8), ma8, mb8, 32'(p8));
      step(1, iv16, ir16, busy16, ov16, or16, a16, b16, ma16, mb16, p16);
    end
  end

  task automatic drive_in(input int u, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (u == 0) begin
      iv8 = v; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv16 = v; a16 = a; b16 = b;
    end
  endtask

  task automatic set_or(input int u, input logic v);
    if (u == 0) or8 = v;
    else        or16 = v;
  endtask

  task automatic wait_ready(input int u);
    logic got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      got = (u == 0) ? ir8 : ir16;
    end
    check("in_ready_timeout", u, got, 1'b1);
  endtask

  task automatic wait_valid(input int u);
    logic got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      got = (u == 0) ? ov8 : ov16;
    end
    check("out_valid_timeout", u, got, 1'b1);
  endtask

  // One full operation; out_ready is withheld for `stall` cycles after the accept edge.
  task automatic run_op(input int u, input logic [15:0] a, input logic [15:0] b, input int stall);
    @(posedge clk); #1;
    drive_in(u, 1'b1, a, b);
    set_or(u, 1'b0);
    wait_ready(u);
    @(posedge clk); #1;
    drive_in(u, 1'b0, a, b);
    n_issued[u]++;
    repeat (stall) @(posedge clk);
    #1 set_or(u, 1'b1);
    wait_valid(u);
    @(posedge clk); #1;
    set_or(u, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive_in(0, 1'b0, '0, '0);
    drive_in(1, 1'b0, '0, '0);
    set_or(0, 1'b0);
    set_or(1, 1'b0);
    n_done   = '{0, 0};
    n_issued = '{0, 0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_op(0, 16'h00FF, 16'h00FF, 0);
    run_op(0, 16'h0000, 16'h00A7, 0);
    run_op(0, 16'h0012, 16'h0034, 10);

    // A second pair is presented while the first is running and must wait for IDLE.
    @(posedge clk); #1;
    drive_in(0, 1'b1, 16'h00C3, 16'h005A);
    set_or(0, 1'b1);
    wait_ready(0);
    @(posedge clk); #1;
    drive_in(0, 1'b1, 16'h0099, 16'h00E7);
    wait_valid(0);
    wait_ready(0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, '0, '0);
    n_issued[0] += 2;
    wait_valid(0);
    @(posedge clk); #1;
    set_or(0, 1'b0);

    // Abort in the second RUN cycle; the partial result must vanish.
    @(posedge clk); #1;
    drive_in(0, 1'b1, 16'h0055, 16'h0066);
    wait_ready(0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, '0, '0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_product", 0, p8, 16'h0000);
    check("post_reset_out_valid", 0, ov8, 1'b0);
    run_op(0, 16'h000F, 16'h0010, 0);

    for (int t = 0; t < 16; t++)
      run_op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)));

    run_op(1, 16'hFFFF, 16'hFFFF, 0);
    run_op(1, 16'h0000, 16'hBEEF, 2);
    run_op(1, 16'hFFFF, 16'h0001, 0);
    for (int t = 0; t < 8; t++)
      run_op(1, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));

    repeat (3) @(posedge clk);
    check("ops_completed", 0, n_done[0], n_issued[0]);
    check("ops_completed", 1, n_done[1], n_issued[1]);
    check("scoreboard_drained", 0, sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
